// File: rtl/axi4_emul_mem_pkg.sv
// Shared types and helpers for the axi4_emul_mem AXI4 slave memory model.
package emul_axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // Word index before truncation to the storage depth; callers keep the low bits.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [7:0]  beat,
                                             input logic [2:0]  size);
    return (addr >> size) + {56'd0, beat};
  endfunction

endpackage

// File: rtl/axi4_emul_mem_array.sv
// Storage for axi4_emul_mem: one asynchronous read port, one byte-strobed synchronous write port.
module axi4_emul_mem_array #(
  parameter int DATA_BITS  = 64,
  parameter int STRB_BITS  = DATA_BITS / 8,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [DATA_BITS-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [STRB_BITS-1:0]  wr_strb,
  input  logic [DATA_BITS-1:0]  wr_data
);

  logic [DATA_BITS-1:0] mem_q [2**DEPTH_LOG2];

  // Write lands at the edge, so a same-cycle read of that word sees the old contents.
  assign rd_data = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_BITS; i++) begin
        if (wr_strb[i]) mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4_emul_mem.sv
// AXI4 slave memory model: independent single-outstanding read and write engines, INCR only.
// Define AXI4_EMUL_MEM_WLAST_CHECK_EN to check w_last against the beat count (protocol_error).
module axi4_emul_mem
  import emul_axi4_pkg::*;
#(
  parameter int ID_BITS      = 4,
  parameter int ADDR_BITS    = 32,
  parameter int DATA_BITS    = 64,
  parameter int STRB_BITS    = DATA_BITS / 8,
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_BITS-1:0] ar_addr,
  input  logic [ID_BITS-1:0]   ar_id,
  input  logic [2:0]           ar_size,
  input  logic [7:0]           ar_len,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_BITS-1:0] aw_addr,
  input  logic [ID_BITS-1:0]   aw_id,
  input  logic [2:0]           aw_size,
  input  logic [7:0]           aw_len,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [STRB_BITS-1:0] w_strb,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 w_last,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [1:0]           r_resp,
  output logic [ID_BITS-1:0]   r_id,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 r_last,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [1:0]           b_resp,
  output logic [ID_BITS-1:0]   b_id,
  output logic                 protocol_error
);

  localparam logic [2:0] FULL_SIZE = 3'($clog2(STRB_BITS));
  localparam logic [7:0] LAT_LOAD  = 8'(READ_LATENCY - 1);

  rd_state_t            rd_state_q, rd_state_d;
  logic [ID_BITS-1:0]   rd_id_q, rd_id_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           rd_len_q, rd_len_d, rd_beat_q, rd_beat_d, rd_cnt_q, rd_cnt_d;
  logic                 rd_err_q, rd_err_d;

  wr_state_t            wr_state_q, wr_state_d;
  logic [ID_BITS-1:0]   wr_id_q, wr_id_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]           wr_len_q, wr_len_d, wr_beat_q, wr_beat_d;
  logic                 wr_err_q, wr_err_d, wl_err_q, wl_err_d, perr_q, perr_d;

  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic [DATA_BITS-1:0]  arr_rdata;
  logic                  mem_we, wlast_bad;

  assign rd_idx = DEPTH_LOG2'(word_index(64'(rd_addr_q), rd_beat_q, FULL_SIZE));
  assign wr_idx = DEPTH_LOG2'(word_index(64'(wr_addr_q), wr_beat_q, FULL_SIZE));

`ifdef AXI4_EMUL_MEM_WLAST_CHECK_EN
  assign wlast_bad = w_last != (wr_beat_q == wr_len_q);
`else
  logic unused_w_last;
  assign unused_w_last = w_last;
  assign wlast_bad     = 1'b0;
`endif

  axi4_emul_mem_array #(
    .DATA_BITS (DATA_BITS),
    .STRB_BITS (STRB_BITS),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clock),
    .rd_idx (rd_idx),
    .rd_data(arr_rdata),
    .wr_en  (mem_we),
    .wr_idx (wr_idx),
    .wr_strb(w_strb),
    .wr_data(w_data)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_beat_d  = rd_beat_q;
    rd_cnt_d   = rd_cnt_q;
    rd_err_d   = rd_err_q;
    ar_ready   = 1'b0;
    r_valid    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        // Ready is masked while reset is held so no request is seen as accepted.
        ar_ready = !reset;
        if (ar_valid) begin
          rd_id_d    = ar_id;
          rd_addr_d  = ar_addr;
          rd_len_d   = ar_len;
          rd_err_d   = ar_size != FULL_SIZE;
          rd_beat_d  = 8'd0;
          rd_cnt_d   = LAT_LOAD;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == 8'd0) rd_state_d = R_BURST;
        else                  rd_cnt_d   = rd_cnt_q - 8'd1;
      end
      R_BURST: begin
        r_valid = 1'b1;
        if (r_ready) begin
          if (rd_beat_q == rd_len_q) rd_state_d = R_IDLE;
          else                       rd_beat_d  = rd_beat_q + 8'd1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign r_id   = r_valid ? rd_id_q : '0;
  assign r_last = r_valid && (rd_beat_q == rd_len_q);
  assign r_resp = (r_valid && rd_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign r_data = (r_valid && !rd_err_q) ? arr_rdata : '0;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_beat_d  = wr_beat_q;
    wr_err_d   = wr_err_q;
    wl_err_d   = wl_err_q;
    perr_d     = perr_q;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        aw_ready = !reset;
        if (aw_valid) begin
          wr_id_d    = aw_id;
          wr_addr_d  = aw_addr;
          wr_len_d   = aw_len;
          wr_err_d   = aw_size != FULL_SIZE;
          wr_beat_d  = 8'd0;
          wl_err_d   = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (w_valid) begin
          // Mis-sized bursts still drain every beat, they just never touch storage.
          mem_we = !wr_err_q;
          if (wlast_bad) begin
            wl_err_d = 1'b1;
            perr_d   = 1'b1;
          end
          if (wr_beat_q == wr_len_q) wr_state_d = W_RESP;
          else                       wr_beat_d  = wr_beat_q + 8'd1;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (b_ready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign b_id           = b_valid ? wr_id_q : '0;
  assign b_resp         = (b_valid && (wr_err_q || wl_err_q)) ? RESP_SLVERR : RESP_OKAY;
  assign protocol_error = perr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_beat_q  <= '0;
      rd_cnt_q   <= '0;
      rd_err_q   <= 1'b0;
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_beat_q  <= '0;
      wr_err_q   <= 1'b0;
      wl_err_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_beat_q  <= rd_beat_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_err_q   <= rd_err_d;
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_beat_q  <= wr_beat_d;
      wr_err_q   <= wr_err_d;
      wl_err_q   <= wl_err_d;
      perr_q     <= perr_d;
    end
  end

endmodule

// File: tb/tb_axi4_emul_mem.sv
// Self-checking bench for axi4_emul_mem: word-level memory model plus per-cycle R/B compare.
module tb_axi4_emul_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic [31:0] ar_addr, aw_addr;
  logic [3:0]  ar_id, aw_id, r_id, b_id;
  logic [2:0]  ar_size, aw_size;
  logic [7:0]  ar_len, aw_len, w_strb;
  logic [63:0] w_data, r_data;
  logic        r_valid, r_ready, r_last, b_valid, b_ready, protocol_error;
  logic [1:0]  r_resp, b_resp;

  axi4_emul_mem dut (
    .clock(clock), .reset(reset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_size(ar_size), .ar_len(ar_len),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_size(aw_size), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_strb(w_strb), .w_data(w_data), .w_last(w_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_resp(r_resp), .r_id(r_id), .r_data(r_data),
    .r_last(r_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
    .protocol_error(protocol_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- model / scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [70:0] exp_r_q[$];   // {last, id, resp, data}
  logic [5:0]  exp_b_q[$];   // {id, resp}
  logic [63:0] r_hist[$];
  logic [63:0] mem_model [int];
  logic [63:0] wd [16];
  logic [7:0]  ws;
  int          rd_first_cyc;
  bit          rd_first_pend = 1'b0;
  bit          perr_exp = 1'b0;
  bit          rr_toggle = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr, input int beat);
    return int'(((addr >> 3) + 32'(beat)) & 32'd4095);
  endfunction

  // ---------------- compare process ----------------
  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      if (r_valid) begin
        if (exp_r_q.size() == 0) begin
          check("r_stray_beat", 72'(r_valid), 72'(0));
        end else begin
          if (rd_first_pend) begin
            check("r_first_latency", 72'(cyc), 72'(rd_first_cyc));
            rd_first_pend = 1'b0;
          end
          check("r_beat", 72'({r_last, r_id, r_resp, r_data}), 72'(exp_r_q[0]));
          if (r_ready) begin
            r_hist.push_back(r_data);
            void'(exp_r_q.pop_front());
          end
        end
      end
      if (b_valid) begin
        if (exp_b_q.size() == 0) begin
          check("b_stray", 72'(b_valid), 72'(0));
        end else begin
          check("b_id_resp", 72'({b_id, b_resp}), 72'(exp_b_q[0]));
          if (b_ready) void'(exp_b_q.pop_front());
        end
      end
    end
  end

  initial begin
    r_ready = 1'b1;
    forever begin
      @(negedge clock);
      r_ready = rr_toggle ? ~r_ready : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_r_empty(input string name);
    int n = 0;
    while (exp_r_q.size() != 0 && n < 300) begin
      @(negedge clock);
      #2;
      n++;
    end
    check(name, 72'(exp_r_q.size()), 72'(0));
    exp_r_q.delete();
  endtask

  task automatic rd_issue(input logic [31:0] addr, input logic [3:0] id,
                          input logic [2:0] size, input int len);
    int n = 0;
    r_hist.delete();
    for (int b = 0; b <= len; b++) begin
      if (size != 3'd3) exp_r_q.push_back({b == len, id, 2'b10, 64'h0});
      else              exp_r_q.push_back({b == len, id, 2'b00, mem_model[word_of(addr, b)]});
    end
    @(negedge clock);
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_size = size; ar_len = 8'(len);
    while (!ar_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("ar_accept", 72'(ar_ready), 72'(1));
    rd_first_cyc  = cyc + 5;
    rd_first_pend = 1'b1;
    @(negedge clock);
    ar_valid = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [3:0] id,
                          input logic [2:0] size, input int len);
    rd_issue(addr, id, size, len);
    wait_r_empty("r_burst_done");
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] id,
                          input logic [2:0] size, input int len, input int bad_beat);
    logic [1:0]  resp;
    logic [63:0] word;
    int          n;
    resp = (size != 3'd3) ? 2'b10 : 2'b00;
`ifdef AXI4_EMUL_MEM_WLAST_CHECK_EN
    if (bad_beat >= 0) begin
      resp     = 2'b10;
      perr_exp = 1'b1;
    end
`endif
    exp_b_q.push_back({id, resp});
    @(negedge clock);
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_size = size; aw_len = 8'(len);
    n = 0;
    while (!aw_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("aw_accept", 72'(aw_ready), 72'(1));
    @(negedge clock);
    aw_valid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      w_valid = 1'b1; w_data = wd[b]; w_strb = ws;
      w_last  = (b == len) ^ (b == bad_beat);
      n = 0;
      while (!w_ready && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("w_accept", 72'(w_ready), 72'(1));
      if (size == 3'd3) begin
        word = mem_model.exists(word_of(addr, b)) ? mem_model[word_of(addr, b)] : 64'h0;
        for (int k = 0; k < 8; k++) if (ws[k]) word[k*8 +: 8] = wd[b][k*8 +: 8];
        mem_model[word_of(addr, b)] = word;
      end
      @(negedge clock);
    end
    w_valid = 1'b0; w_last = 1'b0;
    n = 0;
    while (exp_b_q.size() != 0 && n < 100) begin
      @(negedge clock);
      #2;
      n++;
    end
    check("b_done", 72'(exp_b_q.size()), 72'(0));
    exp_b_q.delete();
    check("protocol_error", 72'(protocol_error), 72'(perr_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ar_ready"}, 72'(ar_ready), 72'(0));
    check({tag, "_aw_ready"}, 72'(aw_ready), 72'(0));
    check({tag, "_w_ready"},  72'(w_ready),  72'(0));
    check({tag, "_r_valid"},  72'(r_valid),  72'(0));
    check({tag, "_b_valid"},  72'(b_valid),  72'(0));
    check({tag, "_r_fields"}, 72'({r_last, r_id, r_resp, r_data}), 72'(0));
    check({tag, "_b_fields"}, 72'({b_id, b_resp}), 72'(0));
    check({tag, "_perr"},     72'(protocol_error), 72'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_size = 0; ar_len = 0;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_size = 0; aw_len = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 1'b1; ws = 8'hFF;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst0");
    reset = 1'b0;
    @(negedge clock);
    check("idle_ar_ready", 72'(ar_ready), 72'(1));
    check("idle_aw_ready", 72'(aw_ready), 72'(1));

    // single-beat write then read, latency 4
    wd[0] = 64'hDEADBEEF_00000001;
    wr_burst(32'h40, 4'd5, 3'd3, 0, -1);
    rd_burst(32'h40, 4'd3, 3'd3, 0);
    check("t1_data", 72'(r_hist[0]), 72'(64'hDEADBEEF_00000001));

    // 4-beat burst, read back with r_ready toggling
    for (int i = 0; i < 4; i++) wd[i] = {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
    wr_burst(32'h0, 4'd9, 3'd3, 3, -1);
    rr_toggle = 1'b1;
    rd_burst(32'h0, 4'd2, 3'd3, 3);
    rr_toggle = 1'b0;
    check("t2_beats", 72'(r_hist.size()), 72'(4));
    check("t2_beat2", 72'(r_hist[2]), 72'(64'hA5A50002_5A5A0002));

    // wrap at the top of storage, and upper address bits ignored
    wd[0] = 64'h0FFF_0FFF_0FFF_0FFF;
    wd[1] = 64'h0000_0000_0000_0ABC;
    wr_burst(32'h7FF8, 4'd1, 3'd3, 1, -1);
    rd_burst(32'h7FF8, 4'd4, 3'd3, 1);
    check("t3_wrap_b0", 72'(r_hist[0]), 72'(64'h0FFF_0FFF_0FFF_0FFF));
    check("t3_wrap_b1", 72'(r_hist[1]), 72'(64'h0000_0000_0000_0ABC));
    rd_burst(32'h8000_0000, 4'd6, 3'd3, 0);
    check("t3_high_addr", 72'(r_hist[0]), 72'(64'h0000_0000_0000_0ABC));

    // wrong size: read returns zeros/SLVERR, write leaves storage alone
    rd_burst(32'h40, 4'd7, 3'd2, 1);
    check("t4_err_beats", 72'(r_hist.size()), 72'(2));
    wd[0] = 64'h5555_5555_5555_5555;
    wr_burst(32'h40, 4'd8, 3'd2, 0, -1);
    rd_burst(32'h40, 4'd3, 3'd3, 0);
    check("t4_unchanged", 72'(r_hist[0]), 72'(64'hDEADBEEF_00000001));

    // byte strobes over an all-ones word
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_burst(32'h100, 4'd2, 3'd3, 0, -1);
    wd[0] = 64'h11111111_22222222;
    ws    = 8'h0F;
    wr_burst(32'h100, 4'd2, 3'd3, 0, -1);
    ws    = 8'hFF;
    rd_burst(32'h100, 4'd12, 3'd3, 0);
    check("t5_strobe", 72'(r_hist[0]), 72'(64'hFFFFFFFF_22222222));

    // early w_last on beat 0 of a 2-beat burst; data still written
    wd[0] = 64'hC0DE_0000_0000_0001;
    wd[1] = 64'hC0DE_0000_0000_0002;
    wr_burst(32'h200, 4'd10, 3'd3, 1, 0);
    rd_burst(32'h200, 4'd13, 3'd3, 1);
    check("t6_beat1", 72'(r_hist[1]), 72'(64'hC0DE_0000_0000_0002));

    // reset in the middle of a read burst
    rd_issue(32'h0, 4'd11, 3'd3, 3);
    n = 0;
    while (exp_r_q.size() > 3 && n < 100) begin
      @(negedge clock);
      #2;
      n++;
    end
    check("t7_first_beat_seen", 72'(exp_r_q.size()), 72'(3));
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    exp_r_q.delete();
    rd_first_pend = 1'b0;
    perr_exp      = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("t7_ar_ready", 72'(ar_ready), 72'(1));
    check("t7_perr", 72'(protocol_error), 72'(0));
    rd_burst(32'h40, 4'd14, 3'd3, 0);
    check("t7_after_reset", 72'(r_hist[0]), 72'(64'hDEADBEEF_00000001));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
